// File: rtl/usb_line_loader.sv
// usb_line_loader: line-oriented word FIFO between the host USB receive path
// and the bluejay display data engine. Tracks write/read positions within a
// display line and within a hologram frame so the consumer knows when a whole
// line is buffered and when a frame has been completely drained.

module usb_line_loader #(
  parameter int WORDS_PER_LINE     = 320,
  parameter int LINES_PER_FRAME    = 1280,
  parameter int FIFO_DEPTH         = 1024,
  parameter int ALMOST_EMPTY_LEVEL = 4
) (
  input  logic                          fpga_clk,
  input  logic                          reset_n,
  input  logic [31:0]                   usb_data,
  input  logic                          usb_valid,
  output logic                          usb_ready,
  input  logic                          get_next_word,
  output logic [31:0]                   fifo_data_out,
  output logic                          line_of_data_available,
  output logic                          sc32_fifo_almost_empty,
  output logic                          buffer_switch_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow_err
);

  // Pointer width indexes the storage; level needs one more bit to hold "full".
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  // Position counters are sized exactly for their ranges.
  localparam int WORD_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LINE_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

  // The FIFO can never hold more complete lines than fit in its depth.
  localparam int MAX_LINES = FIFO_DEPTH / WORDS_PER_LINE;
  localparam int CL_W      = $clog2(MAX_LINES + 1);

  localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES_PER_FRAME - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]  LVL_AE    = LVL_W'(ALMOST_EMPTY_LEVEL);

  logic [31:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [WORD_W-1:0] wr_word_cnt;
  logic [WORD_W-1:0] rd_word_cnt;
  logic [LINE_W-1:0] rd_line_cnt;
  logic [CL_W-1:0]   complete_lines;

  logic              wr_en;
  logic              pop_en;
  logic              fifo_empty;
  logic              line_done_wr;
  logic              line_start_rd;
  logic              rd_word_last;
  logic              frame_done;
  logic [LVL_W-1:0]  level_next;
  logic [CL_W-1:0]   complete_next;

  // Back-pressure comes straight from the level register, so a full FIFO
  // refuses the word and the host holds it; nothing is ever dropped. A pop in
  // the same cycle as full only frees the slot from the following cycle.
  assign usb_ready  = (fifo_level != LVL_FULL);
  assign fifo_empty = (fifo_level == '0);
  assign wr_en      = usb_valid && usb_ready;
  assign pop_en     = get_next_word && !fifo_empty;

  // Line / frame boundary events seen by the write and read sides.
  assign line_done_wr  = wr_en && (wr_word_cnt == WORD_LAST);
  assign line_start_rd = pop_en && (rd_word_cnt == '0);
  assign rd_word_last  = (rd_word_cnt == WORD_LAST);
  assign frame_done    = pop_en && rd_word_last && (rd_line_cnt == LINE_LAST);

  // Show-ahead output: the head word is always presented at the read pointer.
  assign fifo_data_out = mem[rd_ptr];

  // Occupancy update: a simultaneous write and pop leaves the level unchanged.
  always_comb begin
    level_next = fifo_level;
    case ({wr_en, pop_en})
      2'b10:   level_next = fifo_level + LVL_W'(1);
      2'b01:   level_next = fifo_level - LVL_W'(1);
      default: level_next = fifo_level;
    endcase
  end

  // Complete-line bookkeeping: a line counts as consumed as soon as its first
  // word is popped. The decrement is guarded so a consumer reading into a
  // partially written line cannot wrap the counter.
  always_comb begin
    complete_next = complete_lines;
    if (line_done_wr && !line_start_rd) begin
      complete_next = complete_lines + CL_W'(1);
    end else if (!line_done_wr && line_start_rd && (complete_lines != '0)) begin
      complete_next = complete_lines - CL_W'(1);
    end
  end

  // Storage array; contents need no reset because the level gates every read.
  always_ff @(posedge fpga_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= usb_data;
    end
  end

  // Read/write pointers and occupancy; power-of-2 depth makes wrap implicit.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_level <= level_next;
    end
  end

  // Word position within the line currently being written.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      wr_word_cnt <= '0;
    end else if (wr_en) begin
      if (wr_word_cnt == WORD_LAST) begin
        wr_word_cnt <= '0;
      end else begin
        wr_word_cnt <= wr_word_cnt + WORD_W'(1);
      end
    end
  end

  // Word and line position of the reader within the current frame.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      rd_word_cnt <= '0;
      rd_line_cnt <= '0;
    end else if (pop_en) begin
      if (rd_word_last) begin
        rd_word_cnt <= '0;
        if (rd_line_cnt == LINE_LAST) begin
          rd_line_cnt <= '0;
        end else begin
          rd_line_cnt <= rd_line_cnt + LINE_W'(1);
        end
      end else begin
        rd_word_cnt <= rd_word_cnt + WORD_W'(1);
      end
    end
  end

  // Number of fully written lines whose reading has not yet begun.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      complete_lines <= '0;
    end else begin
      complete_lines <= complete_next;
    end
  end

  // Registered status flags computed from next-state values so they line up
  // with the counters they describe.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      line_of_data_available <= 1'b0;
      sc32_fifo_almost_empty <= 1'b1;
      buffer_switch_done     <= 1'b0;
    end else begin
      line_of_data_available <= (complete_next != '0);
      sc32_fifo_almost_empty <= (level_next <= LVL_AE);
      buffer_switch_done     <= frame_done;
    end
  end

  // Sticky underflow: any pop request against an empty FIFO is remembered
  // until the next reset.
  always_ff @(posedge fpga_clk) begin
    if (!reset_n) begin
      underflow_err <= 1'b0;
    end else if (get_next_word && fifo_empty) begin
      underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_line_loader.sv
// tb_usb_line_loader: scoreboard bench for usb_line_loader. One instance uses
// the default geometry, a second uses a tiny 4-word x 2-line frame so frame
// boundaries are reachable quickly.

module tb_usb_line_loader;

  logic        clock;
  logic        reset_n;

  logic [31:0] usb_data;
  logic        usb_valid;
  logic        usb_ready;
  logic        get_next_word;
  logic [31:0] fifo_data_out;
  logic        line_of_data_available;
  logic        sc32_fifo_almost_empty;
  logic        buffer_switch_done;
  logic [10:0] fifo_level;
  logic        underflow_err;

  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        s_get;
  logic [31:0] s_out;
  logic        s_lda;
  logic        s_ae;
  logic        s_bsd;
  logic [4:0]  s_level;
  logic        s_uf;

  int          checks = 0;
  int          errors = 0;
  int          big_pulses = 0;
  int          small_pulses = 0;
  logic [31:0] next_word;

  logic [31:0] exp_q[$];
  logic [31:0] s_exp_q[$];

  usb_line_loader u_dut (
    .fpga_clk               (clock),
    .reset_n                (reset_n),
    .usb_data               (usb_data),
    .usb_valid              (usb_valid),
    .usb_ready              (usb_ready),
    .get_next_word          (get_next_word),
    .fifo_data_out          (fifo_data_out),
    .line_of_data_available (line_of_data_available),
    .sc32_fifo_almost_empty (sc32_fifo_almost_empty),
    .buffer_switch_done     (buffer_switch_done),
    .fifo_level             (fifo_level),
    .underflow_err          (underflow_err)
  );

  usb_line_loader #(
    .WORDS_PER_LINE     (4),
    .LINES_PER_FRAME    (2),
    .FIFO_DEPTH         (16),
    .ALMOST_EMPTY_LEVEL (4)
  ) u_small (
    .fpga_clk               (clock),
    .reset_n                (reset_n),
    .usb_data               (s_data),
    .usb_valid              (s_valid),
    .usb_ready              (s_ready),
    .get_next_word          (s_get),
    .fifo_data_out          (s_out),
    .line_of_data_available (s_lda),
    .sc32_fifo_almost_empty (s_ae),
    .buffer_switch_done     (s_bsd),
    .fifo_level             (s_level),
    .underflow_err          (s_uf)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point shared by the sequencer and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle on the default-geometry instance, then idle its inputs.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic p);
    usb_valid     = v;
    usb_data      = d;
    get_next_word = p;
    @(posedge clock);
    #1;
    usb_valid     = 1'b0;
    get_next_word = 1'b0;
  endtask

  // Drive one cycle on the small-frame instance, then idle its inputs.
  task automatic smallStimulus(input logic v, input logic [31:0] d, input logic p);
    s_valid = v;
    s_data  = d;
    s_get   = p;
    @(posedge clock);
    #1;
    s_valid = 1'b0;
    s_get   = 1'b0;
  endtask

  // Reset both instances and forget everything the scoreboards held.
  task automatic doReset();
    reset_n = 1'b0;
    usb_valid = 1'b0; get_next_word = 1'b0;
    s_valid = 1'b0; s_get = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    exp_q.delete();
    s_exp_q.delete();
    reset_n = 1'b1;
  endtask

  task automatic writeWords(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, next_word, 1'b0);
      next_word++;
    end
  endtask

  task automatic popWords(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
  endtask

  // Monitor: at the falling edge inputs and outputs are stable for the next
  // rising edge. Pops are compared against the queue head, then accepted
  // writes are pushed; frame pulses are counted per cycle.
  always @(negedge clock) begin
    if (reset_n) begin
      if (get_next_word && (fifo_level != 0)) begin
        if (exp_q.size() == 0) begin
          checkOutput("big_pop_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          checkOutput("big_data", fifo_data_out, exp_q.pop_front());
        end
      end
      if (usb_valid && usb_ready) exp_q.push_back(usb_data);
      if (s_get && (s_level != 0)) begin
        if (s_exp_q.size() == 0) begin
          checkOutput("small_pop_unexpected", 32'(s_exp_q.size()), 32'd1);
        end else begin
          checkOutput("small_data", s_out, s_exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) s_exp_q.push_back(s_data);
      if (buffer_switch_done) big_pulses++;
      if (s_bsd) small_pulses++;
    end
  end

  // Directed sequence with hand-computed expectations.
  initial begin
    usb_data = '0; usb_valid = 1'b0; get_next_word = 1'b0;
    s_data = '0; s_valid = 1'b0; s_get = 1'b0;
    next_word = 32'h1000_0000;
    doReset();

    // Reset state.
    checkOutput("rst_ready", 32'(usb_ready), 32'd1);
    checkOutput("rst_lda", 32'(line_of_data_available), 32'd0);
    checkOutput("rst_almost_empty", 32'(sc32_fifo_almost_empty), 32'd1);
    checkOutput("rst_bsd", 32'(buffer_switch_done), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_underflow", 32'(underflow_err), 32'd0);

    // Small frame: two frames of 8 words, pulse only after the 8th pop.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) smallStimulus(1'b1, 32'hA0 + 32'(f * 8 + i), 1'b0);
      checkOutput("small_lda_full", 32'(s_lda), 32'd1);
      for (int k = 0; k < 8; k++) begin
        smallStimulus(1'b0, 32'h0, 1'b1);
        checkOutput($sformatf("small_bsd_f%0d_p%0d", f, k), 32'(s_bsd), (k == 7) ? 32'd1 : 32'd0);
      end
      smallStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("small_bsd_after", 32'(s_bsd), 32'd0);
      checkOutput("small_level_empty", 32'(s_level), 32'd0);
    end
    // Partial frame that will be discarded by the next reset.
    for (int i = 0; i < 6; i++) smallStimulus(1'b1, 32'hB0 + 32'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      smallStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("small_partial_bsd", 32'(s_bsd), 32'd0);
    end

    // One word short of a line, then the completing word.
    writeWords(319);
    checkOutput("l319_lda", 32'(line_of_data_available), 32'd0);
    checkOutput("l319_level", 32'(fifo_level), 32'd319);
    writeWords(1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("l320_lda", 32'(line_of_data_available), 32'd1);
    checkOutput("l320_level", 32'(fifo_level), 32'd320);
    checkOutput("l320_almost_empty", 32'(sc32_fifo_almost_empty), 32'd0);

    // Two lines buffered; availability drops only when line 1 is started.
    writeWords(320);
    popWords(1);
    checkOutput("two_lines_pop1_lda", 32'(line_of_data_available), 32'd1);
    popWords(319);
    checkOutput("line0_done_lda", 32'(line_of_data_available), 32'd1);
    popWords(1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("line1_started_lda", 32'(line_of_data_available), 32'd0);
    checkOutput("line1_started_level", 32'(fifo_level), 32'd319);

    // Fill to the brim, hold a word against back-pressure, pop once.
    writeWords(705);
    checkOutput("full_level", 32'(fifo_level), 32'd1024);
    checkOutput("full_ready", 32'(usb_ready), 32'd0);
    applyStimulus(1'b1, next_word, 1'b0);
    checkOutput("held_level", 32'(fifo_level), 32'd1024);
    applyStimulus(1'b1, next_word, 1'b1);
    checkOutput("full_pop_level", 32'(fifo_level), 32'd1023);
    applyStimulus(1'b1, next_word, 1'b0);
    next_word++;
    checkOutput("refill_level", 32'(fifo_level), 32'd1024);
    popWords(1024);
    checkOutput("drain_level", 32'(fifo_level), 32'd0);
    checkOutput("drain_almost_empty", 32'(sc32_fifo_almost_empty), 32'd1);
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);

    // Underflow is sticky and moves nothing.
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("uf_flag", 32'(underflow_err), 32'd1);
    checkOutput("uf_level", 32'(fifo_level), 32'd0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("uf_sticky", 32'(underflow_err), 32'd1);

    // Reset in the middle of a line discards it.
    writeWords(150);
    doReset();
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_lda", 32'(line_of_data_available), 32'd0);
    checkOutput("mid_rst_underflow", 32'(underflow_err), 32'd0);
    checkOutput("mid_rst_small_level", 32'(s_level), 32'd0);
    checkOutput("mid_rst_small_bsd", 32'(s_bsd), 32'd0);
    writeWords(319);
    checkOutput("post_rst_319_lda", 32'(line_of_data_available), 32'd0);
    writeWords(1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_320_lda", 32'(line_of_data_available), 32'd1);
    checkOutput("post_rst_320_level", 32'(fifo_level), 32'd320);
    popWords(320);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("post_rst_drain_lda", 32'(line_of_data_available), 32'd0);
    checkOutput("post_rst_drain_level", 32'(fifo_level), 32'd0);

    // Pulse accounting: exactly one cycle per completed small frame.
    checkOutput("small_pulse_count", 32'(small_pulses), 32'd2);
    checkOutput("big_pulse_count", 32'(big_pulses), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
